// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// The divide datapath is built only when MULDIV_DIV_EN is defined.
package muldiv_pkg;

    localparam int unsigned MULDIV_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_MUL   = 2'b00,
        OP_MULHU = 2'b01,
        OP_DIVU  = 2'b10,
        OP_REMU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Bit 1 of the op code separates the divide class from the multiply class.
    function automatic logic op_is_div(input logic [1:0] op_code);
        return op_code[1];
    endfunction

    // Bit 0 selects the upper half of the working register: MULHU product high / REMU remainder.
    function automatic logic op_high_half(input logic [1:0] op_code);
        return op_code[0];
    endfunction

endpackage

// File: rtl/muldiv_iter_step.sv
// One combinational iteration: shift-add multiply step or restoring-divide step.
// The compare-subtract path exists only when MULDIV_DIV_EN is defined.
module muldiv_iter_step
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = MULDIV_WIDTH
) (
`ifdef MULDIV_DIV_EN
    input  logic                 is_div,
`endif
    input  logic [2*WIDTH-1:0]   acc,
    input  logic [WIDTH-1:0]     opnd,
    output logic [2*WIDTH-1:0]   acc_next
);

    logic [WIDTH-1:0]   addend_s;
    logic [WIDTH:0]     sum_s;
    logic [2*WIDTH-1:0] mul_next_s;

    // Multiply: upper half accumulates the multiplicand, then the whole register shifts right.
    always_comb begin
        addend_s   = {WIDTH{1'b0}};
        if (acc[0]) begin
            addend_s = opnd;
        end else begin
            addend_s = {WIDTH{1'b0}};
        end
        sum_s      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend_s};
        mul_next_s = {sum_s, acc[WIDTH-1:1]};
    end

`ifdef MULDIV_DIV_EN
    logic [WIDTH:0]     shifted_s;
    logic               ge_s;
    logic [WIDTH-1:0]   rem_next_s;
    logic [2*WIDTH-1:0] div_next_s;

    // Divide: acc holds {remainder, dividend/quotient}; the difference only matters when ge_s,
    // where it always fits in WIDTH bits, so the low WIDTH bits of the subtraction suffice.
    always_comb begin
        shifted_s  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        ge_s       = (shifted_s >= {1'b0, opnd});
        rem_next_s = shifted_s[WIDTH-1:0];
        if (ge_s) begin
            rem_next_s = shifted_s[WIDTH-1:0] - opnd;
        end else begin
            rem_next_s = shifted_s[WIDTH-1:0];
        end
        div_next_s = {rem_next_s, acc[WIDTH-2:0], ge_s};
    end

    // Select the step that matches the latched op class.
    always_comb begin
        acc_next = mul_next_s;
        if (is_div) begin
            acc_next = div_next_s;
        end else begin
            acc_next = mul_next_s;
        end
    end
`else
    // Only the multiply step exists in this build.
    always_comb begin
        acc_next = mul_next_s;
    end
`endif

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative multiply/divide unit with valid/ready handshakes and flush.
// Define MULDIV_DIV_EN to build the divider; otherwise DIVU/REMU return 0 immediately.
module ex_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = MULDIV_WIDTH
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    input  logic [1:0]       op,
    input  logic             flush,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    localparam int unsigned          CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]     CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]     CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(WIDTH - 1);

    state_e             state_r;
    state_e             state_next_s;
    logic [CNT_W-1:0]   count_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [2*WIDTH-1:0] acc_next_s;
    logic [WIDTH-1:0]   opnd_r;
    logic               sel_hi_r;
    logic               out_valid_r;
    logic [WIDTH-1:0]   result_r;
    logic               in_ready_s;
    logic               busy_s;
    logic               accept_s;
    logic               last_step_s;
`ifdef MULDIV_DIV_EN
    logic               div_r;
`endif

    assign accept_s    = (state_r == ST_IDLE) && inValid && !flush;
    assign last_step_s = (state_r == ST_BUSY) && (count_r == CNT_LAST);

    // State register.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; flush overrides every other transition.
    always_comb begin
        state_next_s = state_r;
        if (flush) begin
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (inValid) begin
`ifdef MULDIV_DIV_EN
                        state_next_s = ST_BUSY;
`else
                        state_next_s = op_is_div(op) ? ST_DONE : ST_BUSY;
`endif
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (count_r == CNT_LAST) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_BUSY;
                    end
                end
                ST_DONE: begin
                    if (outReady) begin
                        state_next_s = ST_IDLE;
                    end else begin
                        state_next_s = ST_DONE;
                    end
                end
                default: begin
                    state_next_s = ST_IDLE;
                end
            endcase
        end
    end

    // Handshake/status outputs decoded from the state.
    always_comb begin
        in_ready_s = 1'b0;
        busy_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                in_ready_s = 1'b1;
                busy_s     = 1'b0;
            end
            ST_BUSY: begin
                in_ready_s = 1'b0;
                busy_s     = 1'b1;
            end
            ST_DONE: begin
                in_ready_s = 1'b0;
                busy_s     = 1'b1;
            end
            default: begin
                in_ready_s = 1'b0;
                busy_s     = 1'b0;
            end
        endcase
    end

    // Working register: multiply keeps {acc, multiplier} with the multiplicand in opnd_r;
    // divide keeps {remainder, dividend} with the divisor in opnd_r.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            acc_r    <= {(2*WIDTH){1'b0}};
            opnd_r   <= {WIDTH{1'b0}};
            sel_hi_r <= 1'b0;
            count_r  <= CNT_ZERO;
        end else if (accept_s) begin
            sel_hi_r <= op_high_half(op);
            count_r  <= CNT_ZERO;
            if (op_is_div(op)) begin
                acc_r  <= {{WIDTH{1'b0}}, operandA};
                opnd_r <= operandB;
            end else begin
                acc_r  <= {{WIDTH{1'b0}}, operandB};
                opnd_r <= operandA;
            end
        end else if (state_r == ST_BUSY) begin
            acc_r   <= acc_next_s;
            count_r <= count_r + CNT_ONE;
        end else begin
            acc_r   <= acc_r;
            count_r <= count_r;
        end
    end

`ifdef MULDIV_DIV_EN
    // Op class latched at acceptance.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            div_r <= 1'b0;
        end else if (accept_s) begin
            div_r <= op_is_div(op);
        end else begin
            div_r <= div_r;
        end
    end
`endif

    muldiv_iter_step #(
        .WIDTH    (WIDTH)
    ) u_step (
`ifdef MULDIV_DIV_EN
        .is_div   (div_r),
`endif
        .acc      (acc_r),
        .opnd     (opnd_r),
        .acc_next (acc_next_s)
    );

    // Result and valid: loaded on the final step, cleared on handshake or flush.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            out_valid_r <= 1'b0;
            result_r    <= {WIDTH{1'b0}};
        end else if (flush) begin
            out_valid_r <= 1'b0;
        end else if (last_step_s) begin
            out_valid_r <= 1'b1;
            if (sel_hi_r) begin
                result_r <= acc_next_s[2*WIDTH-1:WIDTH];
            end else begin
                result_r <= acc_next_s[WIDTH-1:0];
            end
`ifndef MULDIV_DIV_EN
        end else if (accept_s && op_is_div(op)) begin
            out_valid_r <= 1'b1;
            result_r    <= {WIDTH{1'b0}};
`endif
        end else if ((state_r == ST_DONE) && outReady) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign inReady  = in_ready_s;
    assign busy     = busy_s;
    assign outValid = out_valid_r;
    assign result   = result_r;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed self-checking bench for ex_muldiv_unit; divide expectations follow MULDIV_DIV_EN.
module tb_ex_muldiv_unit;

    logic        clk;
    logic        resetN;
    logic        inValid;
    logic        inReady;
    logic [31:0] operandA;
    logic [31:0] operandB;
    logic [1:0]  op;
    logic        flush;
    logic        outValid;
    logic        outReady;
    logic [31:0] result;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    ex_muldiv_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .resetN   (resetN),
        .inValid  (inValid),
        .inReady  (inReady),
        .operandA (operandA),
        .operandB (operandB),
        .op       (op),
        .flush    (flush),
        .outValid (outValid),
        .outReady (outReady),
        .result   (result),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one op; latency = edges after the acceptance edge until outValid is seen.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat;
        check_eq({tag, " inReady before"}, {31'd0, inReady}, 32'd1);
        inValid  = 1'b1;
        op       = o;
        operandA = a;
        operandB = b;
        @(posedge clk); #1;
        inValid = 1'b0;
        lat = 0;
        while (!outValid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq({tag, " latency"}, lat, exp_lat);
        check_eq({tag, " result"}, result, exp);
        if (outReady) begin
            @(posedge clk); #1;
            check_eq({tag, " inReady after"}, {31'd0, inReady}, 32'd1);
            check_eq({tag, " outValid after"}, {31'd0, outValid}, 32'd0);
        end
    endtask

    initial begin
        int ov_seen;
        int busy_seen;
        resetN   = 1'b0;
        inValid  = 1'b0;
        operandA = 32'd0;
        operandB = 32'd0;
        op       = 2'b00;
        flush    = 1'b0;
        outReady = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst inReady", {31'd0, inReady}, 32'd1);
        check_eq("rst outValid", {31'd0, outValid}, 32'd0);
        check_eq("rst result", result, 32'd0);
        check_eq("rst busy", {31'd0, busy}, 32'd0);
        resetN = 1'b1;
        @(posedge clk); #1;

        run_op("mul 7x6", 2'b00, 32'd7, 32'd6, 32'h0000002A, 32);
        run_op("mulhu ff", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32);
        run_op("mul ff", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32);
        run_op("mulhu 2^16", 2'b01, 32'h00010000, 32'h00010000, 32'h00000001, 32);
        run_op("mul 2^16", 2'b00, 32'h00010000, 32'h00010000, 32'h00000000, 32);
`ifdef MULDIV_DIV_EN
        run_op("divu 100/7", 2'b10, 32'd100, 32'd7, 32'h0000000E, 32);
        run_op("remu 100/7", 2'b11, 32'd100, 32'd7, 32'h00000002, 32);
        run_op("divu 5/0", 2'b10, 32'd5, 32'd0, 32'hFFFFFFFF, 32);
        run_op("remu 5/0", 2'b11, 32'd5, 32'd0, 32'h00000005, 32);
`else
        run_op("divu 100/7", 2'b10, 32'd100, 32'd7, 32'h00000000, 0);
        run_op("remu 100/7", 2'b11, 32'd100, 32'd7, 32'h00000000, 0);
        run_op("divu 5/0", 2'b10, 32'd5, 32'd0, 32'h00000000, 0);
        run_op("remu 5/0", 2'b11, 32'd5, 32'd0, 32'h00000000, 0);
`endif

        // Backpressure: result held for 10 cycles while a new request waits.
        outReady = 1'b0;
        run_op("bp mul 3x5", 2'b00, 32'd3, 32'd5, 32'd15, 32);
        inValid  = 1'b1;
        op       = 2'b00;
        operandA = 32'd9;
        operandB = 32'd9;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check_eq("bp result", result, 32'd15);
            check_eq("bp outValid", {31'd0, outValid}, 32'd1);
            check_eq("bp busy", {31'd0, busy}, 32'd1);
            check_eq("bp inReady", {31'd0, inReady}, 32'd0);
        end
        inValid  = 1'b0;
        outReady = 1'b1;
        @(posedge clk); #1;
        check_eq("bp release outValid", {31'd0, outValid}, 32'd0);
        check_eq("bp release inReady", {31'd0, inReady}, 32'd1);
        check_eq("bp release busy", {31'd0, busy}, 32'd0);

        // Flush at iteration 10 with a competing request.
        inValid  = 1'b1;
        op       = 2'b00;
        operandA = 32'h00001234;
        operandB = 32'h00000010;
        @(posedge clk); #1;
        inValid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check_eq("fl busy before", {31'd0, busy}, 32'd1);
        flush    = 1'b1;
        inValid  = 1'b1;
        operandA = 32'd5;
        operandB = 32'd5;
        @(posedge clk); #1;
        flush   = 1'b0;
        inValid = 1'b0;
        check_eq("fl busy", {31'd0, busy}, 32'd0);
        check_eq("fl inReady", {31'd0, inReady}, 32'd1);
        check_eq("fl outValid", {31'd0, outValid}, 32'd0);
        ov_seen   = 0;
        busy_seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (outValid) ov_seen++;
            if (busy) busy_seen++;
        end
        check_eq("fl no outValid", ov_seen, 32'd0);
        check_eq("fl no capture", busy_seen, 32'd0);
        run_op("fl mul 3x3", 2'b00, 32'd3, 32'd3, 32'd9, 32);

        // Asynchronous reset at iteration 20.
        inValid  = 1'b1;
        op       = 2'b00;
        operandA = 32'h000000AB;
        operandB = 32'h000000CD;
        @(posedge clk); #1;
        inValid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check_eq("ar busy before", {31'd0, busy}, 32'd1);
        #2;
        resetN = 1'b0;
        #1;
        check_eq("ar outValid", {31'd0, outValid}, 32'd0);
        check_eq("ar result", result, 32'd0);
        check_eq("ar busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        resetN = 1'b1;
        @(posedge clk); #1;
        check_eq("ar inReady", {31'd0, inReady}, 32'd1);
        check_eq("ar outValid after", {31'd0, outValid}, 32'd0);
        run_op("ar mul 0xAB*0xCD", 2'b00, 32'h000000AB, 32'h000000CD, 32'h000088EF, 32);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
